game_status_uart_tx: RTL and testbench

//  Return-path UART transmitter. Game logic -> host, after each guess is resolved.

---
 rtl/uart_pkg.sv | 27 ++
 rtl/uart_byte_tx.sv | 112 +++++++++++
 rtl/game_status_uart_tx.sv | 124 ++++++++++++
 tb/tb_game_status_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and constants for the game-status UART transmitter.
package uart_pkg;

  localparam int         DEFAULT_CLKS_PER_BIT = 1042;
  localparam logic [7:0] HEADER               = 8'hA5;

  typedef enum logic [1:0] {
    B_IDLE,
    B_START,
    B_DATA,
    B_STOP
  } byte_state_t;

  typedef enum logic [1:0] {
    P_IDLE,
    P_LOAD,
    P_WAIT,
    P_FIN
  } pkt_state_t;

  function automatic logic [7:0] packet_checksum(input logic [7:0] b1,
                                                 input logic [7:0] b2,
                                                 input logic [7:0] b3);
    return b1 ^ b2 ^ b3;
  endfunction

endpackage

// File: rtl/uart_byte_tx.sv
// 8N1 byte serializer, LSB first. A start request seen in the last stop-bit
// cycle chains the next frame with no idle gap.
module uart_byte_tx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       serial,
  output logic       byte_busy,
  output logic       byte_done
);

  localparam int            CW   = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  byte_state_t   state, state_n;
  logic [CW-1:0] baud_cnt, baud_cnt_n;
  logic [2:0]    bit_idx, bit_idx_n;
  logic [7:0]    shreg, shreg_n;
  logic          serial_n;
  logic          last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= B_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      serial   <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_cnt_n;
      bit_idx  <= bit_idx_n;
      shreg    <= shreg_n;
      serial   <= serial_n;
    end
  end

  assign last      = (baud_cnt == LAST);
  assign byte_busy = (state != B_IDLE);

  // serial_n is the line level for the next cycle, so the pin stays a pure flop
  always_comb begin
    state_n    = state;
    baud_cnt_n = baud_cnt;
    bit_idx_n  = bit_idx;
    shreg_n    = shreg;
    serial_n   = serial;
    byte_done  = 1'b0;
    case (state)
      B_IDLE: begin
        serial_n = 1'b1;
        if (start) begin
          state_n    = B_START;
          baud_cnt_n = '0;
          shreg_n    = data;
          serial_n   = 1'b0;
        end
      end
      B_START: begin
        if (last) begin
          state_n    = B_DATA;
          baud_cnt_n = '0;
          bit_idx_n  = '0;
          serial_n   = shreg[0];
          shreg_n    = {1'b0, shreg[7:1]};
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      B_DATA: begin
        if (last) begin
          baud_cnt_n = '0;
          if (bit_idx == 3'd7) begin
            state_n  = B_STOP;
            serial_n = 1'b1;
          end else begin
            bit_idx_n = bit_idx + 3'd1;
            serial_n  = shreg[0];
            shreg_n   = {1'b0, shreg[7:1]};
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      B_STOP: begin
        if (last) begin
          byte_done  = 1'b1;
          baud_cnt_n = '0;
          if (start) begin
            state_n  = B_START;
            shreg_n  = data;
            serial_n = 1'b0;
          end else begin
            state_n = B_IDLE;
          end
        end else begin
          baud_cnt_n = baud_cnt + 1'b1;
        end
      end
      default: begin
        state_n  = B_IDLE;
        serial_n = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/game_status_uart_tx.sv
// Latches one game-status snapshot and sends it to the host as a 5-byte
// packet: header, letter, score, index mask, XOR checksum.
module game_status_uart_tx #(
  parameter int         CLKS_PER_BIT = uart_pkg::DEFAULT_CLKS_PER_BIT,
  parameter logic [7:0] HEADER       = uart_pkg::HEADER
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send_valid,
  input  logic [7:0] letter,
  input  logic [2:0] correct,
  input  logic [2:0] incorrect,
  input  logic [4:0] indexCorrect,
  input  logic       gameEnd,
  input  logic       mistake,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_serial
);

  import uart_pkg::*;

  pkt_state_t pstate, pstate_n;
  logic [2:0] byte_idx, byte_idx_n;
  logic [2:0] next_idx;
  logic [7:0] snap_letter, snap_status;
  logic [4:0] snap_index;
  logic       accept;
  logic       byte_start;
  logic [7:0] byte_data;
  logic [7:0] next_byte;
  logic       byte_busy;
  logic       byte_done;

  uart_byte_tx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_byte_tx (
    .clk      (clk),
    .rst      (rst),
    .start    (byte_start),
    .data     (byte_data),
    .serial   (tx_serial),
    .byte_busy(byte_busy),
    .byte_done(byte_done)
  );

  // The byte engine is never idle between accept and the last stop bit
  assign busy    = byte_busy;
  assign accept  = send_valid && !busy;
  assign tx_done = (pstate == P_FIN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pstate      <= P_IDLE;
      byte_idx    <= '0;
      snap_letter <= '0;
      snap_status <= '0;
      snap_index  <= '0;
    end else begin
      pstate   <= pstate_n;
      byte_idx <= byte_idx_n;
      if (accept) begin
        snap_letter <= letter;
        snap_status <= {correct, incorrect, gameEnd, mistake};
        snap_index  <= indexCorrect;
      end
    end
  end

  assign next_idx = byte_idx + 3'd1;

  always_comb begin
    next_byte = packet_checksum(snap_letter, snap_status, {3'b000, snap_index});
    case (next_idx)
      3'd1:    next_byte = snap_letter;
      3'd2:    next_byte = snap_status;
      3'd3:    next_byte = {3'b000, snap_index};
      default: ;
    endcase
  end

  // The header goes out on the accept edge itself, before the snapshot is visible
  always_comb begin
    pstate_n   = pstate;
    byte_idx_n = byte_idx;
    byte_start = 1'b0;
    byte_data  = HEADER;
    case (pstate)
      P_IDLE: begin
        byte_idx_n = '0;
        if (accept) begin
          pstate_n   = P_LOAD;
          byte_start = 1'b1;
        end
      end
      P_LOAD: begin
        pstate_n = P_WAIT;
      end
      P_WAIT: begin
        if (byte_done) begin
          if (byte_idx < 3'd4) begin
            pstate_n   = P_LOAD;
            byte_idx_n = next_idx;
            byte_start = 1'b1;
            byte_data  = next_byte;
          end else begin
            pstate_n = P_FIN;
          end
        end
      end
      P_FIN: begin
        if (accept) begin
          pstate_n   = P_LOAD;
          byte_idx_n = '0;
          byte_start = 1'b1;
        end else begin
          pstate_n = P_IDLE;
        end
      end
      default: pstate_n = P_IDLE;
    endcase
  end

endmodule

// File: tb/tb_game_status_uart_tx.sv
// Randomized bench for game_status_uart_tx: every bit cell of each packet is
// compared with a frame built from the accepted snapshot.
module tb_game_status_uart_tx;

  localparam int CLKS       = 4;
  localparam int PKT_CYCLES = 50 * CLKS;

  typedef struct {
    logic [7:0] letter;
    logic [2:0] correct;
    logic [2:0] incorrect;
    logic [4:0] index;
    logic       game_end;
    logic       mistake;
  } snapshot_t;

  typedef logic [7:0] packet_t [5];

  logic       clk = 1'b0;
  logic       rst;
  logic       send_valid;
  logic [7:0] letter;
  logic [2:0] correct;
  logic [2:0] incorrect;
  logic [4:0] indexCorrect;
  logic       gameEnd;
  logic       mistake;
  logic       busy;
  logic       tx_done;
  logic       tx_serial;

  int checkCount = 0;
  int passCount  = 0;

  always #5 clk = ~clk;

  game_status_uart_tx #(
    .CLKS_PER_BIT(CLKS),
    .HEADER      (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .send_valid  (send_valid),
    .letter      (letter),
    .correct     (correct),
    .incorrect   (incorrect),
    .indexCorrect(indexCorrect),
    .gameEnd     (gameEnd),
    .mistake     (mistake),
    .busy        (busy),
    .tx_done     (tx_done),
    .tx_serial   (tx_serial)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
  endtask

  function automatic snapshot_t randomSnapshot();
    snapshot_t s;
    s.letter    = 8'($urandom_range(0, 255));
    s.correct   = 3'($urandom_range(0, 7));
    s.incorrect = 3'($urandom_range(0, 7));
    s.index     = 5'($urandom_range(0, 31));
    s.game_end  = 1'($urandom_range(0, 1));
    s.mistake   = 1'($urandom_range(0, 1));
    return s;
  endfunction

  // Reference packet from the field weights of the status byte
  function automatic packet_t modelPacket(input snapshot_t s);
    packet_t p;
    int      status;
    status = int'(s.correct) * 32 + int'(s.incorrect) * 4
           + int'(s.game_end) * 2 + int'(s.mistake);
    p[0] = 8'hA5;
    p[1] = s.letter;
    p[2] = 8'(status);
    p[3] = 8'(int'(s.index));
    p[4] = p[1] ^ p[2] ^ p[3];
    return p;
  endfunction

  task automatic driveSnapshot(input snapshot_t s);
    letter       = s.letter;
    correct      = s.correct;
    incorrect    = s.incorrect;
    indexCorrect = s.index;
    gameEnd      = s.game_end;
    mistake      = s.mistake;
  endtask

  task automatic applyStimulus(input snapshot_t s);
    driveSnapshot(s);
    send_valid = 1'b1;
  endtask

  task automatic idleCheck(input int cycles);
    for (int n = 0; n < cycles; n++) begin
      @(negedge clk);
      checkOutput("idle_serial", 32'(tx_serial), 32'd1);
      checkOutput("idle_busy", 32'(busy), 32'd0);
      checkOutput("idle_done", 32'(tx_done), 32'd0);
    end
  endtask

  // Called at the negedge of the accept cycle; k counts cycles after accept
  task automatic checkPacket(input packet_t exp, input int pokeAt, input bit freeze,
                             input bit chain, input snapshot_t nextSnap,
                             input int abortAt);
    logic [7:0] got [5];
    int         bitpos, b, j;
    logic       expBit;
    for (int i = 0; i < 5; i++) got[i] = 8'h00;
    for (int k = 1; k <= PKT_CYCLES + 1; k++) begin
      @(negedge clk);
      if (k <= PKT_CYCLES) begin
        bitpos = (k - 1) / CLKS;
        b      = bitpos / 10;
        j      = bitpos % 10;
        expBit = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : exp[b][j-1];
        checkOutput($sformatf("serial_c%0d", k), 32'(tx_serial), 32'(expBit));
        checkOutput("busy_during", 32'(busy), 32'd1);
        checkOutput("done_early", 32'(tx_done), 32'd0);
        if (((k - 1) % CLKS) == CLKS / 2 && j >= 1 && j <= 8) got[b][j-1] = tx_serial;
      end else begin
        checkOutput("tx_done_pulse", 32'(tx_done), 32'd1);
        checkOutput("busy_release", 32'(busy), 32'd0);
        checkOutput("serial_end", 32'(tx_serial), 32'd1);
      end
      if (k == 1) begin
        send_valid = 1'b0;
        if (freeze) driveSnapshot(randomSnapshot());
      end
      if (pokeAt != 0 && k == pokeAt) begin
        send_valid = 1'b1;
        letter     = 8'h5A;
      end
      if (pokeAt != 0 && k == pokeAt + 1) send_valid = 1'b0;
      if (chain && k == PKT_CYCLES - 1) begin
        driveSnapshot(nextSnap);
        send_valid = 1'b1;
      end
      if (abortAt != 0 && k == abortAt) begin
        rst = 1'b1;
        #1;
        checkOutput("abort_serial", 32'(tx_serial), 32'd1);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(tx_done), 32'd0);
        return;
      end
    end
    for (int i = 0; i < 5; i++)
      checkOutput($sformatf("byte%0d", i), 32'(got[i]), 32'(exp[i]));
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    snapshot_t s, s2;
    packet_t   fixedBytes;
    fixedBytes = '{8'hA5, 8'h41, 8'h65, 8'h14, 8'h30};

    rst = 1'b1;
    send_valid = 1'b0;
    driveSnapshot('{8'h00, 3'd0, 3'd0, 5'd0, 1'b0, 1'b0});
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      checkOutput("reset_serial", 32'(tx_serial), 32'd1);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_done", 32'(tx_done), 32'd0);
    end
    rst = 1'b0;
    idleCheck(20);

    $display("[TB] single packet with busy rejection at cycle 50");
    s = '{8'h41, 3'd3, 3'd1, 5'b10100, 1'b0, 1'b1};
    applyStimulus(s);
    checkPacket(fixedBytes, 50, 1'b0, 1'b0, s, 0);
    idleCheck(10);

    $display("[TB] random packets with snapshot freeze");
    for (int n = 0; n < 4; n++) begin
      s = randomSnapshot();
      applyStimulus(s);
      checkPacket(modelPacket(s), int'($urandom_range(2, 190)), 1'b1, 1'b0, s, 0);
      idleCheck(int'($urandom_range(1, 6)));
    end

    $display("[TB] back-to-back packets");
    s  = randomSnapshot();
    s2 = randomSnapshot();
    applyStimulus(s);
    checkPacket(modelPacket(s), 0, 1'b0, 1'b1, s2, 0);
    checkPacket(modelPacket(s2), 0, 1'b0, 1'b0, s2, 0);
    idleCheck(5);

    $display("[TB] reset during byte 2, data bit 3");
    s = randomSnapshot();
    applyStimulus(s);
    checkPacket(modelPacket(s), 0, 1'b0, 1'b0, s, 1 + 2 * 10 * CLKS + 4 * CLKS + 1);
    send_valid = 1'b0;
    for (int n = 0; n < 2; n++) begin
      @(negedge clk);
      checkOutput("inreset_serial", 32'(tx_serial), 32'd1);
      checkOutput("inreset_done", 32'(tx_done), 32'd0);
    end
    rst = 1'b0;
    idleCheck(5);
    s = randomSnapshot();
    applyStimulus(s);
    checkPacket(modelPacket(s), 0, 1'b1, 1'b0, s, 0);
    idleCheck(5);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
